// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multicycle processor control FSM (Moore-style datapath controls)
//
// Walks each instruction through FETCH/DECODE and then through the execute and
// write-back steps for its opcode. Memory-touching states (FETCH, MEMRD, MEMWR)
// stall until mem_ready is high. All outputs are decoded from the current
// state. The only exception is the FETCH ir_write/pc_write pair, which is also
// qualified by mem_ready.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset; forces FETCH, outputs 0
//   opcode[5:0]    in   instruction[31:26] from the IR, stable outside FETCH
//   mem_ready      in   memory access completes this cycle
//   pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//   mem_to_reg, reg_dst, reg_write, alu_src_a
//                  out  single-bit datapath controls
//   alu_src_b[1:0], alu_op[1:0], pc_source[1:0]
//                  out  mux selects (alu_op: 00 add, 01 sub, 10 funct)
//   illegal_op     out  high in DECODE when the opcode is unsupported
//   state[3:0]     out  current state code, for debug
// -----------------------------------------------------------------------------
module mc_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e state_q, state_d;

    // NOTE: state register uses non-blocking assignment and an asynchronous
    // reset so that the FSM is in FETCH the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR, so anything other than sw is a load.
            MEMADR: state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: state_d = FETCH;
            // Unused codes 12-15 recover to FETCH.
            default: state_d = FETCH;
        endcase
    end

    // Output decode. During reset everything is held low, independent of clk,
    // even though the state register already reads FETCH.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    // Latch the instruction and bump the PC only on the
                    // cycle the memory actually returns data.
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI:
                            illegal_op = 1'b0;
                        default:
                            illegal_op = 1'b1;
                    endcase
                end
                MEMADR, ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEMRD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEMWR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ADDIWB: reg_write = 1'b1;
                ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- self-checking bench for mc_ctrl.
// A reference model expands each opcode into the list of states the
// instruction visits. It gives the control word expected in each state. Inputs
// are driven and outputs sampled on the falling edge, away from the active
// rising edge.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       illegal_op;
    } ctl_t;

    ctl_t obs;
    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, illegal_op};

    mc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit supported(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // States visited by one instruction, FETCH first.
    function automatic void path_of(input logic [5:0] op, ref int seq[$]);
        seq = {0, 1};
        case (op)
            6'b100011: seq = {seq, 2, 3, 4};
            6'b101011: seq = {seq, 2, 5};
            6'b000000: seq = {seq, 6, 7};
            6'b001000: seq = {seq, 10, 11};
            6'b000100: seq = {seq, 8};
            6'b000010: seq = {seq, 9};
            default: ;
        endcase
    endfunction

    function automatic bit waits_on_mem(input int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    // Control word required in state s.
    function automatic ctl_t ctl_of(input int s, input logic mr, input logic [5:0] op);
        ctl_t c = '0;
        case (s)
            0: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
            1: begin c.alu_src_b = 2'b11; c.illegal_op = !supported(op); end
            2, 10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            3: begin c.mem_read = 1; c.i_or_d = 1; end
            4: begin c.reg_write = 1; c.mem_to_reg = 1; end
            5: begin c.mem_write = 1; c.i_or_d = 1; end
            6: begin c.alu_src_a = 1; c.alu_op = 2'b10; end
            7: begin c.reg_write = 1; c.reg_dst = 1; end
            8: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            9: begin c.pc_write = 1; c.pc_source = 2'b10; end
            11: c.reg_write = 1;
            default: ;
        endcase
        return c;
    endfunction

    // Runs one instruction from FETCH, comparing every cycle against the model.
    // fstall/mstall: mem_ready=0 cycles in FETCH and in MEMRD/MEMWR.
    // rand_mr: randomise mem_ready in states that ignore it.
    task automatic run_instr(input string name, input logic [5:0] op,
                             input int fstall, input int mstall, input bit rand_mr);
        int   seq[$];
        int   idx = 0;
        int   cyc = 0;
        int   s;
        logic mr;
        ctl_t exp_c;
        path_of(op, seq);
        opcode = op;
        while (idx < seq.size()) begin
            s  = seq[idx];
            mr = rand_mr ? logic'($urandom_range(0, 1)) : 1'b1;
            if (waits_on_mem(s)) begin
                mr = 1'b1;
                if (s == 0 && fstall > 0) begin mr = 1'b0; fstall--; end
                else if (s != 0 && mstall > 0) begin mr = 1'b0; mstall--; end
            end
            mem_ready = mr;
            #1;
            exp_c = ctl_of(s, mr, op);
            checks++;
            if (state !== 4'(s) || obs !== exp_c) begin
                errors++;
                $display("FAIL %s cycle %0d: state got %0d want %0d, ctl got %h want %h",
                         name, cyc, state, s, obs, exp_c);
            end
            if (mr || !waits_on_mem(s)) idx++;
            cyc++;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0; opcode = 6'b100011; mem_ready = 1'b1;
        #3;
        checks++;
        if (state !== 4'd0 || obs !== ctl_t'('0)) begin
            errors++;
            $display("FAIL reset_hold: state %0d ctl %h want 0/0", state, obs);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 4'd0 || obs !== ctl_t'('0)) begin
            errors++;
            $display("FAIL reset_clocked: state %0d ctl %h want 0/0", state, obs);
        end
        // Release with memory not ready: FETCH must be active and held.
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || obs !== ctl_of(0, 1'b0, opcode)) begin
            errors++;
            $display("FAIL reset_release: state %0d ctl %h want 0/%h", state, obs, ctl_of(0, 1'b0, opcode));
        end
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || obs !== ctl_of(0, 1'b0, opcode)) begin
            errors++;
            $display("FAIL reset_first_edge: state %0d ctl %h want 0/%h", state, obs, ctl_of(0, 1'b0, opcode));
        end
    endtask

    task automatic test_lw;        run_instr("lw", 6'b100011, 0, 0, 0);      endtask
    task automatic test_sw_stall;  run_instr("sw_stall", 6'b101011, 0, 2, 0); endtask
    task automatic test_rtype;     run_instr("rtype", 6'b000000, 0, 0, 0);   endtask
    task automatic test_addi;      run_instr("addi", 6'b001000, 0, 0, 0);    endtask

    task automatic test_beq_j;
        run_instr("beq", 6'b000100, 0, 0, 0);
        run_instr("j", 6'b000010, 0, 0, 0);
    endtask

    task automatic test_illegal;
        run_instr("illegal_3f", 6'b111111, 0, 0, 0);
        run_instr("illegal_01", 6'b000001, 0, 0, 0);
    endtask

    task automatic test_fetch_stall;
        run_instr("fetch_stall", 6'b100011, 3, 1, 0);
    endtask

    // lw is aborted in MEMRD: reset must clear outputs immediately.
    task automatic test_reset_mid;
        opcode = 6'b100011; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 4'd3) begin
            errors++;
            $display("FAIL mid_reach_memrd: state %0d want 3", state);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || obs !== ctl_t'('0)) begin
            errors++;
            $display("FAIL mid_reset_async: state %0d ctl %h want 0/0", state, obs);
        end
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || obs !== ctl_t'('0)) begin
            errors++;
            $display("FAIL mid_reset_after_edge: state %0d ctl %h want 0/0", state, obs);
        end
        rst_n = 1'b1;
        run_instr("after_mid_reset", 6'b101011, 1, 1, 0);
    endtask

    task automatic test_random;
        logic [5:0] ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 5)];
            else                          op = 6'($urandom);
            run_instr("random", op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; mem_ready = 1'b0;
        @(negedge clk);
        test_reset;
        // Complete the FETCH that test_reset left stalled.
        mem_ready = 1'b1;
        @(negedge clk);
        // Bring the FSM back to FETCH via the illegal-opcode path.
        opcode = 6'b111111;
        @(negedge clk);
        test_lw;
        test_sw_stall;
        test_rtype;
        test_addi;
        test_beq_j;
        test_illegal;
        test_fetch_stall;
        test_reset_mid;
        test_random;
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL final_state: state %0d want 0", state);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, rising-edge; reset rst_n is asynchronous and active-low.
REQ-002 clk  in  1  system clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 opcode  in  6  instruction[31:26] from the instruction register, stable outside FETCH.
REQ-005 mem_ready  in  1  memory access completes this cycle.
REQ-006 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath controls.
REQ-007 alu_src_b, alu_op, pc_source  out  2 each  mux selects; alu_op feeds alu_ctrl (00 add, 01 subtract, 10 decode funct).
REQ-008 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-009 state  out  4  current state code, for debug.

Function
REQ-010 The block SHALL be a multicycle control FSM with state codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-011 Supported opcodes SHALL be R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
REQ-012 Outputs SHALL be decoded from state (Moore); every output not listed for a state SHALL be 0.
REQ-013 FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write SHALL be 1 only when mem_ready=1.
REQ-014 DECODE: alu_src_b=11, alu_op=00.
REQ-015 MEMADR and ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
REQ-016 MEMRD: mem_read=1, i_or_d=1.  MEMWR: mem_write=1, i_or_d=1.
REQ-017 MEMWB: reg_write=1, mem_to_reg=1.  ADDIWB: reg_write=1.  ALUWB: reg_write=1, reg_dst=1.
REQ-018 EXEC: alu_src_a=1, alu_op=10.
REQ-019 BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
REQ-020 JUMP: pc_write=1, pc_source=10.
REQ-021 FETCH, MEMRD and MEMWR SHALL hold state while mem_ready=0, keeping their outputs stable; they advance on the first edge with mem_ready=1.
REQ-022 Transitions: FETCH->DECODE; DECODE->MEMADR (lw/sw), EXEC (R), BRANCH (beq), JUMP (j), ADDIEX (addi), FETCH (other).
REQ-023 MEMADR->MEMRD for lw, MEMWR for sw; MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB.
REQ-024 MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP SHALL return to FETCH on the next edge.
REQ-025 illegal_op SHALL be 1 in DECODE exactly when opcode is unsupported, otherwise 0.
REQ-026 Any unused state code (12-15) SHALL return to FETCH on the next edge with all outputs 0.
REQ-027 Instruction latency in clocks with mem_ready=1: lw 5, sw 4, R 4, addi 4, beq 3, j 3; each mem_ready=0 cycle adds one clock.

Reset
REQ-028 While rst_n=0, state SHALL be FETCH and every output SHALL be forced to 0, independent of clk.
REQ-029 On the first rising clk edge after rst_n rises, state SHALL remain FETCH, with REQ-013 outputs active.
REQ-030 Asserting rst_n mid-instruction SHALL abort it immediately with no write strobe asserted after the reset edge.

Verification
REQ-031 Reset then lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-032 sw (101011), mem_ready low for 2 cycles in MEMWR -> state 5 held 3 cycles, mem_write=1 and i_or_d=1 throughout, then state 0.
REQ-033 R-type (000000) -> states 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1 and reg_write=1 in state 7.
REQ-034 beq (000100) then j (000010) -> 0,1,8,0 with alu_op=01, pc_write_cond=1, pc_source=01; then 0,1,9,0 with pc_write=1, pc_source=10.
REQ-035 opcode 111111 -> illegal_op=1 for one cycle in DECODE, no write strobe, state returns to 0.
REQ-036 FETCH with mem_ready=0 for 3 cycles -> ir_write=0 and pc_write=0 while waiting, both 1 in the completing cycle; rst_n=0 in state 3 -> all outputs 0 at once.
